return_stack: RTL and testbench

- Hardware return-address stack; the counterpart of the program counter's load port.
- On a call, it captures the return address derived from the program counter output. On a return, it supplies the saved address and a one-cycle load strobe back into the program counter's in/load inputs.
- Sits beside the program counter in the 16-bit CPU datapath, between the control decoder and the program counter.

---
 rtl/return_stack_pkg.sv | 22 ++
 rtl/return_stack_if.sv | 31 +++
 rtl/return_stack_regfile.sv | 34 +++
 rtl/return_stack.sv | 140 ++++++++++++++
 tb/tb_return_stack.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/return_stack_pkg.sv
//------------------------------------------------------------------------------
// Module   : return_stack_pkg
// Brief    : Shared defaults and {push,pop} operation encoding for return_stack.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package return_stack_pkg;

    localparam int RS_WIDTH_DEFAULT = 16;
    localparam int RS_DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_REPL = 2'b11
    } rs_op_e;

endpackage : return_stack_pkg

`default_nettype wire

// File: rtl/return_stack_if.sv
//------------------------------------------------------------------------------
// Module   : return_stack_if
// Brief    : Call/return handshake between the control decoder and return_stack.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface return_stack_if #(
    parameter int WIDTH = 16
);
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] out;
    logic             load;
    logic             empty;
    logic             full;
    logic             error;

    modport master (
        output push, pop, push_data,
        input  out, load, empty, full, error
    );

    modport slave (
        input  push, pop, push_data,
        output out, load, empty, full, error
    );
endinterface : return_stack_if

`default_nettype wire

// File: rtl/return_stack_regfile.sv
//------------------------------------------------------------------------------
// Module   : rs_regfile
// Brief    : DEPTH x WIDTH storage, one synchronous write port, one async read.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rs_regfile #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are don't-care after reset, so the array carries no reset.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : rs_regfile

`default_nettype wire

// File: rtl/return_stack.sv
//------------------------------------------------------------------------------
// Module   : return_stack
// Brief    : Hardware return-address stack feeding the program counter load port.
//            Build option RS_WRAP_EN: push while full overwrites the oldest entry.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module return_stack
    import return_stack_pkg::*;
#(
    parameter int WIDTH = RS_WIDTH_DEFAULT,
    parameter int DEPTH = RS_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    return_stack_if.slave bus
);

    localparam logic [PTR_W:0] C_COUNT_MAX = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] r_tp;
    logic [PTR_W:0]   r_count;
    logic             r_error;
    logic [WIDTH-1:0] r_out;
    logic             r_load;

    logic [PTR_W-1:0] w_tp_nxt;
    logic [PTR_W:0]   w_count_nxt;
    logic             w_error_nxt;
    logic [WIDTH-1:0] w_out_nxt;
    logic             w_load_nxt;
    logic             w_we;
    logic [PTR_W-1:0] w_waddr;
    logic [PTR_W-1:0] w_top;
    logic [WIDTH-1:0] w_top_data;
    logic             w_empty;
    logic             w_full;
    rs_op_e           w_op;

    assign w_top   = r_tp - PTR_W'(1);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_COUNT_MAX);
    assign w_op    = rs_op_e'({bus.push, bus.pop});

    rs_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_regfile (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (bus.push_data),
        .raddr (w_top),
        .rdata (w_top_data)
    );

    always_comb begin
        w_tp_nxt    = r_tp;
        w_count_nxt = r_count;
        w_error_nxt = r_error;
        w_out_nxt   = r_out;
        w_load_nxt  = 1'b0;
        w_we        = 1'b0;
        w_waddr     = r_tp;

        case (w_op)
            OP_PUSH: begin
                if (!w_full) begin
                    w_we        = 1'b1;
                    w_tp_nxt    = r_tp + PTR_W'(1);
                    w_count_nxt = r_count + (PTR_W+1)'(1);
                end else begin
`ifdef RS_WRAP_EN
                    // Next free slot is the oldest entry once the ring is full.
                    w_we     = 1'b1;
                    w_tp_nxt = r_tp + PTR_W'(1);
`else
                    w_error_nxt = 1'b1;
`endif
                end
            end
            OP_POP: begin
                if (!w_empty) begin
                    w_out_nxt   = w_top_data;
                    w_load_nxt  = 1'b1;
                    w_tp_nxt    = w_top;
                    w_count_nxt = r_count - (PTR_W+1)'(1);
                end else begin
                    w_error_nxt = 1'b1;
                end
            end
            OP_REPL: begin
                if (!w_empty) begin
                    // Old top is read and replaced in place on the same edge.
                    w_out_nxt  = w_top_data;
                    w_load_nxt = 1'b1;
                    w_we       = 1'b1;
                    w_waddr    = w_top;
                end else begin
                    // Empty stack cannot be full (DEPTH >= 2): plain push plus underflow.
                    w_we        = 1'b1;
                    w_tp_nxt    = r_tp + PTR_W'(1);
                    w_count_nxt = r_count + (PTR_W+1)'(1);
                    w_error_nxt = 1'b1;
                end
            end
            default: begin
                w_load_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tp    <= '0;
            r_count <= '0;
            r_error <= 1'b0;
            r_out   <= '0;
            r_load  <= 1'b0;
        end else begin
            r_tp    <= w_tp_nxt;
            r_count <= w_count_nxt;
            r_error <= w_error_nxt;
            r_out   <= w_out_nxt;
            r_load  <= w_load_nxt;
        end
    end

    assign bus.out   = r_out;
    assign bus.load  = r_load;
    assign bus.empty = w_empty;
    assign bus.full  = w_full;
    assign bus.error = r_error;

endmodule : return_stack

`default_nettype wire

// File: tb/tb_return_stack.sv
//------------------------------------------------------------------------------
// Module   : tb_return_stack
// Brief    : Self-checking bench for return_stack against a queue-based model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_return_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic clk;
    logic reset;

    return_stack_if #(.WIDTH(WIDTH)) rs_bus ();

    return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rs_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue back is the stack top.
    logic [WIDTH-1:0] m_q [$];
    logic [WIDTH-1:0] m_out;
    logic             m_load;
    logic             m_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".out"},   32'(rs_bus.out),   32'(m_out));
        check_val({tag, ".load"},  32'(rs_bus.load),  32'(m_load));
        check_val({tag, ".empty"}, 32'(rs_bus.empty), 32'(m_q.size() == 0));
        check_val({tag, ".full"},  32'(rs_bus.full),  32'(m_q.size() == DEPTH));
        check_val({tag, ".error"}, 32'(rs_bus.error), 32'(m_err));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_out  = '0;
        m_load = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic o, input logic [WIDTH-1:0] d);
        m_load = 1'b0;
        if (p && !o) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(d);
            end else begin
`ifdef RS_WRAP_EN
                void'(m_q.pop_front());
                m_q.push_back(d);
`else
                m_err = 1'b1;
`endif
            end
        end else if (!p && o) begin
            if (m_q.size() > 0) begin
                m_out  = m_q.pop_back();
                m_load = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end else if (p && o) begin
            if (m_q.size() > 0) begin
                m_out  = m_q.pop_back();
                m_load = 1'b1;
                m_q.push_back(d);
            end else begin
                m_q.push_back(d);
                m_err = 1'b1;
            end
        end
    endtask

    task automatic step(input string tag, input logic p, input logic o, input logic [WIDTH-1:0] d);
        @(negedge clk);
        rs_bus.push      = p;
        rs_bus.pop       = o;
        rs_bus.push_data = d;
        @(posedge clk);
        #1;
        model_step(p, o, d);
        check_all(tag);
    endtask

    // Asserts reset away from any clock edge and checks it acts without one.
    task automatic reset_now(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rs_bus.push = 1'b0;
        rs_bus.pop  = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #1;
        reset_now(tag);
    endtask

    initial begin
        rs_bus.push      = 1'b0;
        rs_bus.pop       = 1'b0;
        rs_bus.push_data = '0;
        reset            = 1'b1;
        model_reset();

        // Reset state, then idle
        do_reset("rst");
        step("idle0", 1'b0, 1'b0, '0);
        step("idle1", 1'b0, 1'b0, '0);
        check_val("rst.out_zero", 32'(rs_bus.out), 32'h0);

        // LIFO ordering
        for (int i = 1; i <= 3; i++) step("lifo_push", 1'b1, 1'b0, WIDTH'(i));
        step("lifo_pop3", 1'b0, 1'b1, '0);
        check_val("lifo.first", 32'(rs_bus.out), 32'h3);
        step("lifo_pop2", 1'b0, 1'b1, '0);
        step("lifo_pop1", 1'b0, 1'b1, '0);
        check_val("lifo.last", 32'(rs_bus.out), 32'h1);
        step("lifo_idle", 1'b0, 1'b0, '0);

        // Fill, push while full, then drain
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, WIDTH'(16'h0100 + i));
        check_val("fill.full", 32'(rs_bus.full), 32'h1);
        step("overfull", 1'b1, 1'b0, 16'hFFFF);
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, '0);
        step("drain_idle", 1'b0, 1'b0, '0);

        // Tail-call replace
        do_reset("rst_repl");
        step("repl_push", 1'b1, 1'b0, 16'h00FF);
        step("repl", 1'b1, 1'b1, 16'h1234);
        check_val("repl.out", 32'(rs_bus.out), 32'h00FF);
        step("repl_pop", 1'b0, 1'b1, '0);
        check_val("repl_pop.out", 32'(rs_bus.out), 32'h1234);

        // Underflow is sticky
        do_reset("rst_uf");
        step("uf_pop", 1'b0, 1'b1, '0);
        check_val("uf.error", 32'(rs_bus.error), 32'h1);
        step("uf_push", 1'b1, 1'b0, 16'h0005);
        step("uf_repl_empty", 1'b0, 1'b1, '0);
        step("repl_empty", 1'b1, 1'b1, 16'h0777);

        // Reset between edges with a load strobe in flight
        do_reset("rst_mid0");
        step("mid_push_a", 1'b1, 1'b0, 16'h0AAA);
        step("mid_push_b", 1'b1, 1'b0, 16'h0BBB);
        step("mid_pop", 1'b0, 1'b1, '0);
        #2;
        reset_now("mid_reset");
        step("mid_after_pop", 1'b0, 1'b1, '0);

        // Randomized traffic, push-heavy then pop-heavy
        do_reset("rst_rand");
        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            logic p, o;
            r = $urandom_range(0, 9);
            if (i < 300) begin
                p = (r >= 2 && r <= 6) || r == 9;
                o = (r >= 7);
            end else begin
                p = (r >= 2 && r <= 3) || r == 9;
                o = (r >= 4);
            end
            step("rand", p, o, WIDTH'($urandom));
            if (i == 150 || i == 450) do_reset("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_return_stack

`default_nettype wire
